commit_scheduler: RTL

- In-order commit controller for the register file's write port.
- Tracks in-flight instructions in a circular reorder queue:
  - allocates a tag per issued instruction;
  - captures results from the common data bus;
  - retires the head entry to the register file one per cycle.
- On a mispredicted branch at commit it raises the pipeline-wide clear.

---
 rtl/commit_scheduler.sv | 128 ++++++++++++
 1 files changed

// File: rtl/commit_scheduler.sv
// In-order commit controller: circular reorder queue that allocates tags at issue,
// captures CDB results, retires the head to the register file and raises a flush on mispredict.
module commit_scheduler #(
  parameter int ROB_WIDTH = 4
) (
  input  logic                 clockIn,
  input  logic                 resetIn,
  input  logic                 readyIn,
  input  logic                 allocValid,
  input  logic                 allocHasRd,
  input  logic [4:0]           allocRd,
  input  logic                 allocIsBranch,
  output logic                 allocReady,
  output logic [ROB_WIDTH-1:0] allocId,
  input  logic                 cdbValid,
  input  logic [ROB_WIDTH-1:0] cdbId,
  input  logic [31:0]          cdbValue,
  input  logic                 cdbMispredict,
  input  logic [ROB_WIDTH-1:0] query1Id,
  output logic                 query1Ready,
  output logic [31:0]          query1Value,
  input  logic [ROB_WIDTH-1:0] query2Id,
  output logic                 query2Ready,
  output logic [31:0]          query2Value,
  output logic                 writeFlag,
  output logic [ROB_WIDTH-1:0] robId,
  output logic [4:0]           writeAddr,
  output logic [31:0]          writeValue,
  output logic                 clearOut
);

  localparam int DEPTH = 1 << ROB_WIDTH;
  localparam logic [ROB_WIDTH:0]   FULL_CNT = (ROB_WIDTH+1)'(DEPTH);
  localparam logic [ROB_WIDTH:0]   CNT_ONE  = (ROB_WIDTH+1)'(1);
  localparam logic [ROB_WIDTH-1:0] PTR_ONE  = ROB_WIDTH'(1);

  logic [DEPTH-1:0]     r_valid;
  logic [DEPTH-1:0]     r_done;
  logic [DEPTH-1:0]     r_hasRd;
  logic [DEPTH-1:0]     r_isBranch;
  logic [DEPTH-1:0]     r_mispredict;
  logic [4:0]           r_rd    [DEPTH];
  logic [31:0]          r_value [DEPTH];
  logic [ROB_WIDTH-1:0] r_head;
  logic [ROB_WIDTH-1:0] r_tail;
  logic [ROB_WIDTH:0]   r_count;
  logic                 r_clear;

  logic w_alloc;
  logic w_commit;
  logic w_flush;
  logic w_capture;

  assign allocReady = (r_count != FULL_CNT) & ~r_clear;
  assign allocId    = r_tail;

  assign w_alloc   = allocValid & allocReady & readyIn;
  assign w_commit  = readyIn & r_valid[r_head] & r_done[r_head] & ~r_clear;
  assign w_flush   = w_commit & r_isBranch[r_head] & r_mispredict[r_head];
  // No same-cycle forwarding: a capture only becomes visible from the next cycle.
  assign w_capture = cdbValid & readyIn & ~r_clear & r_valid[cdbId];

  assign writeFlag  = w_commit & r_hasRd[r_head] & (r_rd[r_head] != 5'd0);
  assign robId      = r_head;
  assign writeAddr  = r_rd[r_head];
  assign writeValue = r_value[r_head];
  assign clearOut   = r_clear;

  assign query1Ready = r_valid[query1Id] & r_done[query1Id];
  assign query1Value = r_value[query1Id];
  assign query2Ready = r_valid[query2Id] & r_done[query2Id];
  assign query2Value = r_value[query2Id];

  always_ff @(posedge clockIn or negedge resetIn) begin
    if (!resetIn) begin
      r_valid <= '0;
      r_done  <= '0;
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
      r_clear <= 1'b0;
    end else if (readyIn) begin
      if (r_clear) begin
        r_clear <= 1'b0;
      end else if (w_flush) begin
        // The mispredicted branch retires, then everything younger (and any same-cycle alloc) is dropped.
        r_clear <= 1'b1;
        r_valid <= '0;
        r_done  <= '0;
        r_head  <= '0;
        r_tail  <= '0;
        r_count <= '0;
      end else begin
        if (w_capture) begin
          r_done[cdbId] <= 1'b1;
        end
        if (w_commit) begin
          r_valid[r_head] <= 1'b0;
          r_head          <= r_head + PTR_ONE;
        end
        if (w_alloc) begin
          r_valid[r_tail] <= 1'b1;
          r_done[r_tail]  <= 1'b0;
          r_tail          <= r_tail + PTR_ONE;
        end
        case ({w_alloc, w_commit})
          2'b10:   r_count <= r_count + CNT_ONE;
          2'b01:   r_count <= r_count - CNT_ONE;
          default: r_count <= r_count;
        endcase
      end
    end
  end

  // Payload storage is qualified by the control valid/done bits, so it needs no reset.
  always_ff @(posedge clockIn) begin
    if (w_capture) begin
      r_value[cdbId]      <= cdbValue;
      r_mispredict[cdbId] <= cdbMispredict;
    end
    if (w_alloc) begin
      r_hasRd[r_tail]    <= allocHasRd;
      r_rd[r_tail]       <= allocRd;
      r_isBranch[r_tail] <= allocIsBranch;
    end
  end

endmodule
